hart_puls_filter: RTL and testbench

Conditions the raw heartbeat-sensor signal into clean single-cycle beat pulses for the heart-rate measurement stage directly downstream, whose beat input expects exactly one `clk`-wide pulse per heartbeat. The raw input is synchronised, debounced and blanked for a refractory period so contact bounce and double peaks cannot produce extra pulses. A stuck or absent sensor is flagged after a timeout.

---
 rtl/hart_puls_filter_pkg.sv | 21 ++
 rtl/hart_puls_filter_if.sv | 9 +
 rtl/hart_puls_filter_sync.sv | 20 ++
 rtl/hart_puls_filter.sv | 93 +++++++++
 tb/tb_hart_puls_filter.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/hart_puls_filter_pkg.sv
// Shared types and 50 MHz default timing for the heartbeat pulse filter.
package hartslag_pkg;

  typedef enum logic [1:0] {
    LAAG       = 2'd0,
    BEVESTIG   = 2'd1,
    REFRACTAIR = 2'd2,
    WACHT_LAAG = 2'd3
  } hart_state_e;

  localparam int unsigned SYNC_STAGES_DEF       = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF   = 50_000;
  localparam int unsigned REFRACTORY_CYCLES_DEF = 12_500_000;
  localparam int unsigned TIMEOUT_CYCLES_DEF    = 150_000_000;

  // Bits needed to hold max_val itself, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hart_puls_filter_if.sv
// Sensor-side bundle: raw beat level in, clean beat pulse and no-beat flag out.
interface hart_puls_filter_if;
  logic ruw_in;
  logic puls_uit;
  logic geen_hartslag;

  modport master (output ruw_in, input puls_uit, input geen_hartslag);
  modport slave  (input ruw_in, output puls_uit, output geen_hartslag);
endinterface

// File: rtl/hart_puls_filter_sync.sv
// N-stage synchroniser for asynchronous sensor levels, async active-low reset.
module hart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/hart_puls_filter.sv
// Turns the raw heartbeat level into one-cycle beat pulses with debounce and refractory blanking.
// Optional no-beat timeout flag is compiled in with HARTSLAG_TIMEOUT_EN.
module hart_puls_filter
  import hartslag_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REFRACTORY_CYCLES = REFRACTORY_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DEF
) (
  input logic               clk,
  input logic               reset,
  hart_puls_filter_if.slave bus
);

  localparam int unsigned DEB_W = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int unsigned REF_W = cnt_width(REFRACTORY_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRACTORY_CYCLES - 1);

  logic             sync_in;
  hart_state_e      state;
  logic [DEB_W-1:0] deb_cnt;
  logic [REF_W-1:0] ref_cnt;
  logic             puls_reg;

  hart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.ruw_in),
    .q     (sync_in)
  );

  // Counters only step while below their terminal value, so they can never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LAAG;
      deb_cnt  <= '0;
      ref_cnt  <= '0;
      puls_reg <= 1'b0;
    end else begin
      puls_reg <= 1'b0;
      case (state)
        LAAG: begin
          if (sync_in) begin
            state   <= BEVESTIG;
            deb_cnt <= '0;
          end
        end
        BEVESTIG: begin
          if (!sync_in) begin
            state <= LAAG;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= REFRACTAIR;
            ref_cnt  <= '0;
            puls_reg <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        REFRACTAIR: begin
          if (ref_cnt == REF_LAST) state   <= WACHT_LAAG;
          else                     ref_cnt <= ref_cnt + 1'b1;
        end
        WACHT_LAAG: begin
          if (!sync_in) state <= LAAG;
        end
        default: state <= LAAG;
      endcase
    end
  end

  assign bus.puls_uit = puls_reg;

`ifdef HARTSLAG_TIMEOUT_EN
  localparam int unsigned TO_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt;

  // A beat pulse clears the count even on the cycle it would have saturated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                to_cnt <= '0;
    else if (puls_reg)         to_cnt <= '0;
    else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
  end

  assign bus.geen_hartslag = (to_cnt == TO_MAX);
`else
  assign bus.geen_hartslag = 1'b0;
`endif

endmodule

// File: tb/tb_hart_puls_filter.sv
// Directed bench for hart_puls_filter with DEBOUNCE=4, REFRACTORY=20, TIMEOUT=100.
module tb_hart_puls_filter;

`ifdef HARTSLAG_TIMEOUT_EN
  localparam logic GEEN_EXP = 1'b1;
`else
  localparam logic GEEN_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;
  int   pulse_count = 0;
  int   last_pulse_edge = -1;
  int   n0;
  int   base;

  hart_puls_filter_if hif();

  hart_puls_filter #(
    .SYNC_STAGES       (2),
    .DEBOUNCE_CYCLES   (4),
    .REFRACTORY_CYCLES (20),
    .TIMEOUT_CYCLES    (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  always #5 clk = ~clk;

  // Edge numbering plus a record of which edge each pulse followed.
  always @(posedge clk) begin
    edge_n++;
    #1;
    if (hif.puls_uit === 1'b1) begin
      pulse_count++;
      last_pulse_edge = edge_n;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic apply_stimulus(input logic val, input int n);
    hif.ruw_in = val;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    reset      = 1'b0;
    hif.ruw_in = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_puls", hif.puls_uit, 0);
    check_output("reset_geen", hif.geen_hartslag, 0);
    reset = 1'b1;

    // Timeout from reset
    apply_stimulus(0, 99);
    check_output("geen_at_99", hif.geen_hartslag, 0);
    apply_stimulus(0, 1);
    check_output("geen_at_100", hif.geen_hartslag, GEEN_EXP);
    apply_stimulus(0, 20);
    check_output("geen_at_120", hif.geen_hartslag, GEEN_EXP);

    // Clean beat held 40 cycles, pulse after edge N+6
    base = pulse_count;
    n0   = edge_n + 1;
    apply_stimulus(1, 7);
    check_output("clean_puls", hif.puls_uit, 1);
    check_output("clean_edge", last_pulse_edge, n0 + 6);
    check_output("geen_with_puls", hif.geen_hartslag, GEEN_EXP);
    apply_stimulus(1, 1);
    check_output("clean_single", hif.puls_uit, 0);
    check_output("geen_cleared", hif.geen_hartslag, 0);
    apply_stimulus(1, 32);
    apply_stimulus(0, 10);
    check_output("clean_count", pulse_count - base, 1);

    // Glitches: 3 high rejected, 5 high accepted
    base = pulse_count;
    apply_stimulus(1, 3);
    apply_stimulus(0, 10);
    check_output("glitch3_count", pulse_count - base, 0);
    n0 = edge_n + 1;
    apply_stimulus(1, 5);
    apply_stimulus(0, 4);
    check_output("glitch5_count", pulse_count - base, 1);
    check_output("glitch5_edge", last_pulse_edge, n0 + 6);
    apply_stimulus(0, 30);

    // Bounce during refractory, then re-trigger at minimum spacing
    base = pulse_count;
    n0   = edge_n + 1;
    apply_stimulus(1, 5);
    for (int i = 0; i < 18; i++) apply_stimulus(((i / 2) % 2) == 1, 1);
    check_output("bounce_count", pulse_count - base, 1);
    check_output("bounce_edge", last_pulse_edge, n0 + 6);
    apply_stimulus(0, 3);
    apply_stimulus(1, 5);
    apply_stimulus(0, 2);
    check_output("second_puls", hif.puls_uit, 1);
    check_output("second_edge", last_pulse_edge, n0 + 32);
    check_output("second_count", pulse_count - base, 2);
    apply_stimulus(0, 30);

    // Reset at debounce count 2
    base = pulse_count;
    apply_stimulus(1, 5);
    reset = 1'b0;
    #1;
    check_output("midreset_puls", hif.puls_uit, 0);
    check_output("midreset_geen", hif.geen_hartslag, 0);
    apply_stimulus(1, 3);
    hif.ruw_in = 1'b0;
    check_output("midreset_count", pulse_count - base, 0);
    reset = 1'b1;
    apply_stimulus(0, 5);
    n0 = edge_n + 1;
    apply_stimulus(1, 5);
    apply_stimulus(0, 2);
    check_output("after_reset_puls", hif.puls_uit, 1);
    check_output("after_reset_edge", last_pulse_edge, n0 + 6);
    check_output("after_reset_count", pulse_count - base, 1);
    apply_stimulus(0, 30);

    // Stuck high for 200 cycles
    base = pulse_count;
    apply_stimulus(1, 7);
    check_output("stuck_puls", hif.puls_uit, 1);
    apply_stimulus(1, 100);
    check_output("stuck_geen_early", hif.geen_hartslag, 0);
    apply_stimulus(1, 1);
    check_output("stuck_geen_rise", hif.geen_hartslag, GEEN_EXP);
    apply_stimulus(1, 92);
    apply_stimulus(0, 5);
    check_output("stuck_count", pulse_count - base, 1);
    check_output("stuck_geen_hold", hif.geen_hartslag, GEEN_EXP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
